// File: rtl/mod_updown_counter_if.sv
// Bus bundle for mod_updown_counter: control inputs, count, terminal count and wrap pulse.
// With MOD_UPDOWN_COUNTER_GRAY_OUT_EN defined the bundle also carries count_gray.
interface mod_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
`ifdef MOD_UPDOWN_COUNTER_GRAY_OUT_EN
  logic [WIDTH-1:0] count_gray;

  modport master (output en, up, load, load_val, input count, tc, wrap, count_gray);
  modport slave  (input en, up, load, load_val, output count, tc, wrap, count_gray);
`else
  modport master (output en, up, load, load_val, input count, tc, wrap);
  modport slave  (input en, up, load, load_val, output count, tc, wrap);
`endif
endinterface

// File: rtl/mod_updown_counter.sv
// Parametrised modulo-N up/down counter with load, saturate-or-wrap mode, tc flag and wrap pulse.
// Optional feature macro: MOD_UPDOWN_COUNTER_GRAY_OUT_EN adds a registered Gray-coded count output.
module mod_updown_counter #(
  parameter int WIDTH       = 3,
  parameter int MODULUS     = 8,
  parameter int RESET_VALUE = 0,
  parameter int SATURATE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  mod_updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VALUE);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "mod_updown_counter: WIDTH must be >= 1");
  end
  if (MODULUS < 2) begin : g_bad_mod_low
    $fatal(1, "mod_updown_counter: MODULUS must be >= 2");
  end
  if (WIDTH < 31 && MODULUS > (1 << WIDTH)) begin : g_bad_mod_high
    $fatal(1, "mod_updown_counter: MODULUS must be <= 2**WIDTH");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
    $fatal(1, "mod_updown_counter: RESET_VALUE must be < MODULUS");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             atMax, atMin;

  assign atMax = (count_q == MAX_C);
  assign atMin = (count_q == '0);

  // Limits are detected by comparison, so a short modulus never relies on 2**WIDTH rollover.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (!atMax) begin
          count_d = count_q + 1'b1;
        end else if (SATURATE == 0) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!atMin) begin
          count_d = count_q - 1'b1;
        end else if (SATURATE == 0) begin
          count_d = MAX_C;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_C;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = bus.en & (bus.up ? atMax : atMin);

`ifdef MOD_UPDOWN_COUNTER_GRAY_OUT_EN
  function automatic logic [WIDTH-1:0] toGray(input logic [WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  logic [WIDTH-1:0] gray_q;

  // Encoded from the next-state value so the Gray output lands on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= toGray(RST_C);
    end else begin
      gray_q <= toGray(count_d);
    end
  end

  assign bus.count_gray = gray_q;
`endif

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous modulo-N up/down counter with a toggle-style count enable. Successor to the team's fixed 3-bit toggle counter.
- Adds width and modulus generics, direction control, parallel load, saturate-or-wrap mode, a terminal-count flag and a wrap pulse.
- Used as a general event/cycle counter and as a divider or prescaler feeding downstream control FSMs.

Parameters:
- WIDTH, 3, counter width in bits; must be >= 1.
- MODULUS, 8, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
- RESET_VALUE, 0, value loaded on reset; must be < MODULUS.
- SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  count enable (T); the counter steps only when en=1.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when stepping.
- load  input  1  parallel-load strobe.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: en=1 and count is at the limit for the current direction.
- wrap  output  1  registered one-cycle pulse, asserted the cycle after a wrap occurs.

Behaviour:
- Reset is synchronous, active-high: clock is clk, reset is rst; all state changes only on the rising edge of clk.
- On reset: count=RESET_VALUE and wrap=0. tc follows its combinational definition.
- Per-edge priority: rst > load > en > hold.
- Load (load=1):
  - count <= load_val when load_val < MODULUS, otherwise count <= MODULUS-1 (clamped).
  - en and up are ignored that cycle; wrap <= 0.
- Increment (en=1, up=1):
  - count < MODULUS-1: count <= count+1.
  - count == MODULUS-1, SATURATE=0: count <= 0 and wrap <= 1.
  - count == MODULUS-1, SATURATE=1: count holds and wrap <= 0.
- Decrement (en=1, up=0):
  - count > 0: count <= count-1.
  - count == 0, SATURATE=0: count <= MODULUS-1 and wrap <= 1.
  - count == 0, SATURATE=1: count holds and wrap <= 0.
- Hold (en=0, load=0): count holds; wrap <= 0.
- wrap is high for exactly one cycle per wrap event. Back-to-back wraps (e.g. MODULUS=2 with continuous enable) keep wrap high on consecutive cycles.
- tc = en & (up ? count==MODULUS-1 : count==0). tc is valid in SATURATE mode too; it can be used as a carry-in for cascading.
- Arithmetic is unsigned WIDTH-bit. Internal next-value logic must not rely on natural 2**WIDTH overflow when MODULUS < 2**WIDTH.
- A direction change takes effect on the same edge it is sampled. There is no turnaround latency.
- Reset asserted mid-count overrides load and en on that edge. Counting resumes on the first edge with rst=0.
- Latency: every count update is visible on count one clock after the qualifying edge inputs. No pipelining.
- Elaboration check: an illegal parameter set (MODULUS > 2**WIDTH, MODULUS < 2, RESET_VALUE >= MODULUS) must cause a simulation fatal/error at time 0.

Optional Feature:
- Macro: MOD_UPDOWN_COUNTER_GRAY_OUT_EN.
- Defined:
  - Adds output port count_gray, WIDTH bits, registered, equal to the Gray encoding (bin ^ (bin>>1)) of the next-state count.
  - count_gray changes on the same edge as count and always equals gray(count).
  - Reset value is gray(RESET_VALUE).
  - Intended for safe crossing into other clock domains. Gray adjacency is guaranteed only when MODULUS = 2**WIDTH.
- Undefined: port count_gray and its register are absent. All other behaviour is identical.

Test Plan:
- Reset and free-run (WIDTH=3, MODULUS=8, RESET_VALUE=0): rst=1 for 2 cycles, then en=1, up=1 for 10 cycles -> count 0,1,...,7,0,1. tc=1 while count=7. wrap=1 only in the cycle count first shows 0 after 7.
- Modulo-6 down with wrap (MODULUS=6): load load_val=1, then en=1, up=0 -> count 1,0,5,4. tc=1 at count 0. wrap pulses once, in the cycle count=5.
- Saturation (SATURATE=1, MODULUS=8): load 6, en=1, up=1 for 4 cycles -> count 6,7,7,7. wrap stays 0. tc stays 1 while count=7 and en=1.
- Priority and clamp: load=1, en=1, load_val=7 with MODULUS=6 -> count=5 next cycle, wrap=0. Then assert rst=1 together with load=1 -> count=RESET_VALUE.
- Enable gating and direction flip: toggle en 1,0,1,1 with up 1,1,0,0 from count=3 -> count 4,4,3,2. With en=0, tc=0 regardless of count.
- Macro build (MOD_UPDOWN_COUNTER_GRAY_OUT_EN, WIDTH=3): free-run 0..7 -> count_gray 000,001,011,010,110,111,101,100. Exactly one bit changes per step, including the 7->0 wrap.
